if_fetch: RTL and testbench

Instruction-fetch stage sitting directly upstream of the instruction ROM and downstream of the branch/jump resolution logic. It owns the program counter and drives the ROM chip-enable and byte address. It captures the combinational ROM word at each clock edge into a 2-entry fetch queue. The decode stage consumes the queue through a valid/ready handshake; a redirect flushes the queue and restarts fetch at a new PC.

---
 rtl/if_fetch.sv | 134 +++++++++++++
 tb/tb_if_fetch.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM and buffers
// fetched words in a 2-entry queue consumed by decode through valid/ready.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_misalign
);

    localparam int unsigned XLEN     = 32;
    localparam int unsigned CNT_W    = 2;
    localparam logic        CHIP_ENABLE  = 1'b1;
    localparam logic        CHIP_DISABLE = 1'b0;
    localparam logic [XLEN-1:0] ZERO_WORD = '0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            misalign;
    } fq_entry_t;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [XLEN-1:0]  pc;
    fq_entry_t        ent0;
    fq_entry_t        ent1;
    fq_entry_t        new_ent;
    logic [CNT_W-1:0] count;
    logic             pop;
    logic             fetch_go;
    logic             redirect_misaligned;

    assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
    assign new_ent             = '{pc: pc, inst: rom_inst, misalign: 1'b0};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and fetch/pop decisions; a redirect overrides everything.
    always_comb begin
        state_nxt = state;
        fetch_go  = 1'b0;
        pop       = (count != CNT_W'(0)) && id_ready;
        unique case (state)
            BOOT:    state_nxt = RUN;
            RUN:     fetch_go  = (count != CNT_W'(2)) || pop;
            FAULT:   state_nxt = FAULT;
            default: state_nxt = BOOT;
        endcase
        if (redirect_valid) begin
            fetch_go  = 1'b0;
            pop       = 1'b0;
            state_nxt = redirect_misaligned ? FAULT : RUN;
        end
    end

    assign rom_ce   = fetch_go ? CHIP_ENABLE : CHIP_DISABLE;
    assign rom_addr = pc;

    // PC and fetch queue; head always lives in ent0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            ent0  <= '0;
            ent1  <= '0;
            count <= '0;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
            if (redirect_misaligned) begin
                ent0  <= '{pc: redirect_pc, inst: ZERO_WORD, misalign: 1'b1};
                count <= CNT_W'(1);
            end else begin
                count <= '0;
            end
        end else begin
            if (fetch_go) begin
                pc <= pc + XLEN'(4);
            end
            unique case ({fetch_go, pop})
                2'b10: begin
                    if (count == CNT_W'(0)) begin
                        ent0 <= new_ent;
                    end else begin
                        ent1 <= new_ent;
                    end
                    count <= count + CNT_W'(1);
                end
                2'b01: begin
                    ent0  <= ent1;
                    count <= count - CNT_W'(1);
                end
                2'b11: begin
                    if (count == CNT_W'(2)) begin
                        ent0 <= ent1;
                        ent1 <= new_ent;
                    end else begin
                        ent0 <= new_ent;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Head outputs read as zero whenever the queue is empty.
    assign id_valid    = (count != CNT_W'(0));
    assign id_pc       = id_valid ? ent0.pc   : '0;
    assign id_inst     = id_valid ? ent0.inst : ZERO_WORD;
    assign id_misalign = id_valid && ent0.misalign;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: per-cycle vector table plus a scoreboard
// of expected decode handshakes, and a wrap-around check on a second instance.
module tb_if_fetch;

    logic        clk;
    logic        rst_n;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_misalign;

    logic        rom_ce2;
    logic [31:0] rom_addr2;
    logic [31:0] rom_inst2;
    logic        id_valid2;
    logic [31:0] id_pc2;
    logic [31:0] id_inst2;
    logic        id_misalign2;

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] rom_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign rom_inst  = rom_of(rom_addr);
    assign rom_inst2 = rom_of(rom_addr2);

    if_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_inst(id_inst), .id_misalign(id_misalign)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .rom_ce(rom_ce2), .rom_addr(rom_addr2), .rom_inst(rom_inst2),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .id_valid(id_valid2), .id_ready(1'b1),
        .id_pc(id_pc2), .id_inst(id_inst2), .id_misalign(id_misalign2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        ce;
        logic [31:0] addr;
        logic        v;
        logic [31:0] idpc;
        logic        mis;
    } row_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        mis;
    } sb_t;

    row_t rows[$];
    sb_t  sbq[$];

    task automatic row(input logic r, input logic rdy, input logic redir,
                       input logic [31:0] rpc, input logic ce, input logic [31:0] addr,
                       input logic v, input logic [31:0] idpc, input logic mis);
        row_t t;
        t = '{r, rdy, redir, rpc, ce, addr, v, idpc, mis};
        rows.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset release and steady streaming.
        row(0,1,0,0,      0,32'h0,  0,32'h0,0);
        row(1,1,0,0,      0,32'h0,  0,32'h0,0);
        row(1,1,0,0,      1,32'h0,  0,32'h0,0);
        row(1,1,0,0,      1,32'h4,  1,32'h0,0);
        row(1,1,0,0,      1,32'h8,  1,32'h4,0);
        row(1,1,0,0,      1,32'hC,  1,32'h8,0);
        row(1,1,0,0,      1,32'h10, 1,32'hC,0);
        // Reset again, then backpressure from empty.
        row(0,0,0,0,      0,32'h0,  0,32'h0,0);
        row(1,0,0,0,      0,32'h0,  0,32'h0,0);
        row(1,0,0,0,      1,32'h0,  0,32'h0,0);
        row(1,0,0,0,      1,32'h4,  1,32'h0,0);
        row(1,0,0,0,      0,32'h8,  1,32'h0,0);
        row(1,0,0,0,      0,32'h8,  1,32'h0,0);
        row(1,0,0,0,      0,32'h8,  1,32'h0,0);
        row(1,1,0,0,      1,32'h8,  1,32'h0,0);
        row(1,1,0,0,      1,32'hC,  1,32'h4,0);
        // Aligned redirect with a full queue and a pending pop.
        row(1,1,1,32'h40, 0,32'h10, 1,32'h8,0);
        row(1,1,0,0,      1,32'h40, 0,32'h0,0);
        row(1,1,0,0,      1,32'h44, 1,32'h40,0);
        // Misaligned redirect, fault marker, then recovery.
        row(1,1,1,32'h42, 0,32'h48, 1,32'h44,0);
        row(1,0,0,0,      0,32'h42, 1,32'h42,1);
        row(1,1,0,0,      0,32'h42, 1,32'h42,1);
        row(1,1,0,0,      0,32'h42, 0,32'h0,0);
        row(1,1,0,0,      0,32'h42, 0,32'h0,0);
        row(1,1,0,0,      0,32'h42, 0,32'h0,0);
        row(1,1,1,32'h80, 0,32'h42, 0,32'h0,0);
        row(1,1,0,0,      1,32'h80, 0,32'h0,0);
        row(1,1,0,0,      1,32'h84, 1,32'h80,0);
        row(1,1,0,0,      1,32'h88, 1,32'h84,0);
        // Fill to two entries, then asynchronous reset before the next edge.
        row(1,0,0,0,      1,32'h8C, 1,32'h88,0);
        row(1,0,0,0,      0,32'h90, 1,32'h88,0);
        row(0,0,0,0,      0,32'h0,  0,32'h0,0);
        row(1,1,0,0,      0,32'h0,  0,32'h0,0);
        row(1,1,0,0,      1,32'h0,  0,32'h0,0);
        row(1,1,0,0,      1,32'h4,  1,32'h0,0);

        foreach (rows[i]) begin
            row_t        r;
            logic [31:0] exp_inst;
            r = rows[i];
            @(negedge clk);
            rst_n          = r.rst_n;
            id_ready       = r.rdy;
            redirect_valid = r.redir;
            redirect_pc    = r.rpc;
            #1;
            exp_inst = (r.v && !r.mis) ? rom_of(r.idpc) : 32'h0;
            chk($sformatf("row%0d rom_ce", i),      32'(rom_ce),      32'(r.ce));
            chk($sformatf("row%0d rom_addr", i),    rom_addr,         r.addr);
            chk($sformatf("row%0d id_valid", i),    32'(id_valid),    32'(r.v));
            chk($sformatf("row%0d id_pc", i),       id_pc,            r.idpc);
            chk($sformatf("row%0d id_inst", i),     id_inst,          exp_inst);
            chk($sformatf("row%0d id_misalign", i), 32'(id_misalign), 32'(r.mis));

            // Scoreboard model of what decode should receive.
            if (!r.rst_n) begin
                sbq.delete();
            end else if (r.redir) begin
                logic [1:0] lo;
                sbq.delete();
                lo = r.rpc[1:0];
                if (lo != 2'b00) begin
                    sb_t f;
                    f = '{r.rpc, 32'h0, 1'b1};
                    sbq.push_back(f);
                end
            end else begin
                if (id_valid && id_ready) begin
                    if (sbq.size() == 0) begin
                        chk($sformatf("row%0d sb_unexpected_pc", i), id_pc, 32'hxxxx_xxxx);
                    end else begin
                        sb_t e;
                        e = sbq.pop_front();
                        chk($sformatf("row%0d sb_pc", i),   id_pc,            e.pc);
                        chk($sformatf("row%0d sb_inst", i), id_inst,          e.inst);
                        chk($sformatf("row%0d sb_mis", i),  32'(id_misalign), 32'(e.mis));
                    end
                end
                if (r.ce) begin
                    sb_t n;
                    n = '{r.addr, rom_of(r.addr), 1'b0};
                    sbq.push_back(n);
                end
            end
        end

        // PC wrap on the second instance.
        @(negedge clk);
        rst_n    = 1'b0;
        id_ready = 1'b1;
        redirect_valid = 1'b0;
        #1;
        chk("wrap reset rom_addr", rom_addr2, 32'hFFFF_FFF8);
        chk("wrap reset id_valid", 32'(id_valid2), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("wrap boot rom_ce", 32'(rom_ce2), 32'h0);
        @(negedge clk);
        #1;
        chk("wrap first fetch rom_ce", 32'(rom_ce2), 32'h1);
        chk("wrap first fetch addr", rom_addr2, 32'hFFFF_FFF8);
        @(negedge clk);
        #1;
        chk("wrap id_pc0", id_pc2, 32'hFFFF_FFF8);
        @(negedge clk);
        #1;
        chk("wrap id_pc1", id_pc2, 32'hFFFF_FFFC);
        @(negedge clk);
        #1;
        chk("wrap id_pc2", id_pc2, 32'h0000_0000);
        chk("wrap id_inst2", id_inst2, rom_of(32'h0));
        chk("wrap id_valid2", 32'(id_valid2), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
